// File: rtl/alu_issue_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sched_pkg
// Brief    : Shared types for the ALU issue scheduler: opcodes, latencies,
//            reservation slot layout.
// Revision : 1.0 - initial release
// ============================================================================
package sched_pkg;

   localparam int MAX_LAT = 3;
   // Slot fields are sized for the widest supported configuration (NREQ=4).
   localparam int c_SLOT_TAG_W = 6;
   localparam int c_SLOT_SRC_W = 2;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_MUL  = 4'd4,
      OP_SHL  = 4'd5,
      OP_ROT  = 4'd6,
      OP_FADD = 4'd7,
      OP_FMUL = 4'd8,
      OP_IDLE = 4'b1111
   } alu_op_e;

   typedef struct packed {
      logic                    valid;
      logic [c_SLOT_TAG_W-1:0] tag;
      logic [c_SLOT_SRC_W-1:0] src;
   } slot_t;

   // Zero marks an illegal opcode: it never occupies a writeback slot.
   function automatic logic [1:0] lat_f(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: lat_f = 2'd1;
         OP_MUL, OP_SHL, OP_ROT:        lat_f = 2'd2;
         OP_FADD, OP_FMUL:              lat_f = 2'd3;
         default:                       lat_f = 2'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_sched_if
// Brief    : Requester, ALU and writeback buses of the ALU issue scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_sched_if #(
   parameter int DATA_W = 128,
   parameter int NREQ   = 2,
   parameter int TAG_W  = 6
);
   logic [NREQ-1:0]         req_valid;
   logic [NREQ-1:0]         req_ready;
   logic [NREQ*4-1:0]       req_op;
   logic [NREQ*DATA_W-1:0]  req_a;
   logic [NREQ*DATA_W-1:0]  req_b;
   logic [NREQ*TAG_W-1:0]   req_tag;
   logic [3:0]              alu_op;
   logic [DATA_W-1:0]       alu_a;
   logic [DATA_W-1:0]       alu_b;
   logic [DATA_W-1:0]       alu_res;
   logic                    wb_valid;
   logic [DATA_W-1:0]       wb_data;
   logic [TAG_W-1:0]        wb_tag;
   logic [$clog2(NREQ)-1:0] wb_src;
   logic                    busy;

   // Issue stage and ALU side
   modport master (
      output req_valid, req_op, req_a, req_b, req_tag, alu_res,
      input  req_ready, alu_op, alu_a, alu_b, wb_valid, wb_data, wb_tag, wb_src, busy
   );

   // Scheduler side
   modport slave (
      input  req_valid, req_op, req_a, req_b, req_tag, alu_res,
      output req_ready, alu_op, alu_a, alu_b, wb_valid, wb_data, wb_tag, wb_src, busy
   );
endinterface
`default_nettype wire

// File: rtl/alu_issue_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : NREQ-wide round-robin arbiter; pointer advances past each winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  wire logic                    clk,
   input  wire logic                    rst,
   input  wire logic [NREQ-1:0]         i_elig,
   output logic      [NREQ-1:0]         o_grant,
   output logic      [$clog2(NREQ)-1:0] o_win,
   output logic                         o_any
);
   localparam int c_PW = $clog2(NREQ);

   logic [c_PW-1:0] r_ptr;
   int              w_idx;

   always_comb begin
      o_grant = '0;
      o_win   = '0;
      o_any   = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (!o_any && i_elig[w_idx]) begin
            o_any          = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_win          = c_PW'(w_idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (o_any) begin
         r_ptr <= (o_win == c_PW'(NREQ - 1)) ? '0 : o_win + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_sched
// Brief    : Round-robin issue of NREQ requesters onto one shared ALU with a
//            writeback-slot reservation ring. Option: ALU_SCHED_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_sched #(
   parameter int DATA_W  = 128,
   parameter int NREQ    = 2,
   parameter int TAG_W   = 6,
   parameter int MAX_LAT = sched_pkg::MAX_LAT
) (
   input  wire logic        clk_fake,
   input  wire logic        rst,
`ifdef ALU_SCHED_PERF_EN
   alu_issue_sched_if.slave bus,
   output logic [31:0]      perf_issued,
   output logic [31:0]      perf_stall,
   output logic [31:0]      perf_idle
`else
   alu_issue_sched_if.slave bus
`endif
);
   import sched_pkg::*;

   localparam int c_SRC_W = $clog2(NREQ);

   slot_t               r_ring     [MAX_LAT];
   slot_t               w_ring_nxt [MAX_LAT];
   slot_t               w_new_slot;
   logic [MAX_LAT:0]    w_taken;
   logic [NREQ-1:0]     w_elig;
   logic [NREQ-1:0]     w_grant;
   logic [c_SRC_W-1:0]  w_win;
   logic                w_any;
   logic [3:0]          w_win_op;
   logic [1:0]          w_win_lat;
   logic                w_issue;
   logic                w_busy;
   logic [3:0]          r_alu_op;
   logic [DATA_W-1:0]   r_alu_a;
   logic [DATA_W-1:0]   r_alu_b;
   logic                r_wb_valid;
   logic [TAG_W-1:0]    r_wb_tag;
   logic [c_SRC_W-1:0]  r_wb_src;

   // w_taken[L]: slot L-1 of the post-shift ring is already reserved.
   assign w_taken[0] = 1'b0;
   for (genvar gk = 1; gk <= MAX_LAT; gk++) begin : g_taken
      if (gk < MAX_LAT) begin : g_occ
         assign w_taken[gk] = r_ring[gk].valid;
      end else begin : g_top
         assign w_taken[gk] = 1'b0;
      end
   end

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
      logic [1:0] w_lat;
      assign w_lat      = lat_f(bus.req_op[gi*4 +: 4]);
      assign w_elig[gi] = bus.req_valid[gi] & ~w_taken[w_lat];
   end

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .clk     (clk_fake),
      .rst     (rst),
      .i_elig  (w_elig),
      .o_grant (w_grant),
      .o_win   (w_win),
      .o_any   (w_any)
   );

   assign w_win_op  = bus.req_op[int'(w_win)*4 +: 4];
   assign w_win_lat = lat_f(w_win_op);
   // Illegal opcodes are granted (consumed) but never reach the ALU.
   assign w_issue   = w_any && (w_win_lat != 2'd0);

   always_comb begin
      w_new_slot       = '0;
      w_new_slot.valid = 1'b1;
      w_new_slot.tag   = c_SLOT_TAG_W'(bus.req_tag[int'(w_win)*TAG_W +: TAG_W]);
      w_new_slot.src   = c_SLOT_SRC_W'(w_win);
   end

   // Shift first, then reserve: a slot may retire and be re-reserved at once.
   always_comb begin
      for (int i = 0; i < MAX_LAT - 1; i++) w_ring_nxt[i] = r_ring[i+1];
      w_ring_nxt[MAX_LAT-1] = '0;
      if (w_issue) w_ring_nxt[w_win_lat - 2'd1] = w_new_slot;
   end

   always_comb begin
      w_busy = 1'b0;
      for (int i = 0; i < MAX_LAT; i++) w_busy = w_busy | r_ring[i].valid;
   end

   always_ff @(posedge clk_fake or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_LAT; i++) r_ring[i] <= '0;
         r_alu_op   <= OP_IDLE;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_wb_valid <= 1'b0;
         r_wb_tag   <= '0;
         r_wb_src   <= '0;
      end else begin
         for (int i = 0; i < MAX_LAT; i++) r_ring[i] <= w_ring_nxt[i];
         r_wb_valid <= r_ring[0].valid;
         r_wb_tag   <= TAG_W'(r_ring[0].tag);
         r_wb_src   <= c_SRC_W'(r_ring[0].src);
         if (w_issue) begin
            r_alu_op <= w_win_op;
            r_alu_a  <= bus.req_a[int'(w_win)*DATA_W +: DATA_W];
            r_alu_b  <= bus.req_b[int'(w_win)*DATA_W +: DATA_W];
         end else begin
            r_alu_op <= OP_IDLE;
         end
      end
   end

   assign bus.req_ready = rst ? '0 : w_grant;
   assign bus.alu_op    = r_alu_op;
   assign bus.alu_a     = r_alu_a;
   assign bus.alu_b     = r_alu_b;
   assign bus.wb_valid  = r_wb_valid;
   assign bus.wb_data   = bus.alu_res;
   assign bus.wb_tag    = r_wb_tag;
   assign bus.wb_src    = r_wb_src;
   assign bus.busy      = w_busy;

`ifdef ALU_SCHED_PERF_EN
   logic [31:0] r_perf_issued;
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_idle;

   always_ff @(posedge clk_fake or posedge rst) begin
      if (rst) begin
         r_perf_issued <= '0;
         r_perf_stall  <= '0;
         r_perf_idle   <= '0;
      end else begin
         if (w_any && (r_perf_issued != 32'hFFFF_FFFF))
            r_perf_issued <= r_perf_issued + 32'd1;
         if ((bus.req_valid != '0) && !w_any && (r_perf_stall != 32'hFFFF_FFFF))
            r_perf_stall <= r_perf_stall + 32'd1;
         if ((bus.req_valid == '0) && (r_perf_idle != 32'hFFFF_FFFF))
            r_perf_idle <= r_perf_idle + 32'd1;
      end
   end

   assign perf_issued = r_perf_issued;
   assign perf_stall  = r_perf_stall;
   assign perf_idle   = r_perf_idle;
`else
`endif

endmodule
`default_nettype wire
